// File: rtl/detector_pkg.sv
// Shared types and default sizes for the sequence detector and its session controller.
package detector_pkg;

  localparam int DEF_WORD_W     = 24;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_CLR_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SHIFT,
    DONE
  } ctrl_state_t;

  // Requested bit count limited to what the pattern register can hold.
  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/detector_session_ctrl_if.sv
// Control and detector-side signals of one detector test session.
// Optional abort input present when DETCTRL_ABORT_EN is defined.
interface detector_session_ctrl_if
  import detector_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LEN_W  = $clog2(WORD_W + 1),
  parameter int CNT_W  = DEF_CNT_W
);

  logic              start;
  logic [WORD_W-1:0] pattern;
  logic [LEN_W-1:0]  len;
`ifdef DETCTRL_ABORT_EN
  logic              abort;
`endif
  logic              busy;
  logic              done;
  logic              det_rst;
  logic              det_ena;
  logic              det_sig;
  logic              det_z;
  logic [CNT_W-1:0]  hit_count;
  logic              overflow;

  // Requester side: issues sessions and plays the detector's flag back.
  modport master (
`ifdef DETCTRL_ABORT_EN
    output abort,
`endif
    output start, pattern, len, det_z,
    input  busy, done, det_rst, det_ena, det_sig, hit_count, overflow
  );

  // Controller side.
  modport slave (
`ifdef DETCTRL_ABORT_EN
    input  abort,
`endif
    input  start, pattern, len, det_z,
    output busy, done, det_rst, det_ena, det_sig, hit_count, overflow
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with sticky overflow flag.
// Latency: count updates the cycle after inc/clr; clr has priority over inc.
// Backpressure: none; every inc is absorbed, beyond full scale only ovf records it.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&count) begin
        ovf <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/detector_session_ctrl.sv
// Runs detector test sessions: clear, shift a latched pattern in LSB first, count hits, pulse done.
// Latency: first bit CLR_CYCLES+1 cycles after start, done CLR_CYCLES+len+1 cycles after start.
// Backpressure: none; start is taken only in IDLE, ignored while busy. DETCTRL_ABORT_EN adds abort.
module detector_session_ctrl
  import detector_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LEN_W      = $clog2(WORD_W + 1),
  parameter int CNT_W      = DEF_CNT_W,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES
) (
  input logic                    clk,
  input logic                    rst,
  detector_session_ctrl_if.slave bus
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  ctrl_state_t       state;
  logic [WORD_W-1:0] pattern_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [CLR_W-1:0]  clr_cnt;
  logic              abort_req;
  logic              start_acc;
  logic              hit;

`ifdef DETCTRL_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  assign start_acc = (state == IDLE) && bus.start;
  // det_ena is high exactly in SHIFT, so it doubles as the hit qualifier.
  assign hit       = bus.det_ena && bus.det_z;
  assign bus.det_sig = bus.det_ena & pattern_q[idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      idx         <= '0;
      clr_cnt     <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.det_rst <= 1'b1;
      bus.det_ena <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            pattern_q   <= bus.pattern;
            len_q       <= LEN_W'(clamp_len(int'(bus.len), WORD_W));
            clr_cnt     <= '0;
            bus.busy    <= 1'b1;
            bus.det_rst <= 1'b1;
            bus.det_ena <= 1'b0;
            state       <= CLEAR;
          end
        end

        CLEAR: begin
          if (abort_req || ((clr_cnt == CLR_W'(CLR_CYCLES - 1)) && (len_q == '0))) begin
            bus.done    <= 1'b1;
            bus.det_rst <= 1'b0;
            bus.det_ena <= 1'b0;
            state       <= DONE;
          end else if (clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
            idx         <= '0;
            bus.det_rst <= 1'b0;
            bus.det_ena <= 1'b1;
            state       <= SHIFT;
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end

        SHIFT: begin
          idx <= idx + LEN_W'(1);
          if (abort_req || (idx == len_q - LEN_W'(1))) begin
            bus.done    <= 1'b1;
            bus.det_ena <= 1'b0;
            state       <= DONE;
          end
        end

        DONE: begin
          // Detector stays out of reset during DONE so its state can be inspected.
          bus.busy    <= 1'b0;
          bus.det_rst <= 1'b1;
          bus.det_ena <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          bus.busy    <= 1'b0;
          bus.det_rst <= 1'b1;
          bus.det_ena <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_hit_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .inc  (hit),
    .count(bus.hit_count),
    .ovf  (bus.overflow)
  );

endmodule

// File: tb/tb_detector_session_ctrl.sv
// Randomised session bench for detector_session_ctrl against a cycle-indexed reference model.
`timescale 1ns/1ps
module tb_detector_session_ctrl;

  localparam int WORD_W = 24;
  localparam int LEN_W  = $clog2(WORD_W + 1);
  localparam int CNT_W  = 4;
  localparam int CLR    = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  detector_session_ctrl_if #(.WORD_W(WORD_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  detector_session_ctrl #(
    .WORD_W(WORD_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .CLR_CYCLES(CLR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".done"}, bus.done, 0);
    chk({tag, ".det_rst"}, bus.det_rst, 1);
    chk({tag, ".det_ena"}, bus.det_ena, 0);
    chk({tag, ".det_sig"}, bus.det_sig, 0);
    chk({tag, ".hit_count"}, bus.hit_count, m_cnt);
    chk({tag, ".overflow"}, bus.overflow, m_ovf);
  endtask

  task automatic idle_cycles(input int n);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.det_z = 1'($urandom);
      cycle();
      chk_idle("idle");
    end
  endtask

  // One session: the model lays out every cycle from the start edge (k=1) on.
  task automatic run_session(input logic [WORD_W-1:0] pat, input int ln, input logic [31:0] zm,
                             input bit poke, input bit hold, input int abort_at);
    int n, neff, kdone, hits, dones, j;
    bit shifting;
    logic exp_sig;
    n     = (ln > WORD_W) ? WORD_W : ln;
    neff  = (abort_at >= 0 && abort_at < n) ? abort_at + 1 : n;
    kdone = CLR + 1 + neff;
    hits  = 0;
    dones = 0;
    bus.pattern = pat;
    bus.len     = LEN_W'(ln);
    bus.start   = 1'b1;
    for (int k = 1; k <= kdone + 1; k++) begin
      cycle();
      j = k - CLR - 2;
      if (j >= 0 && j < neff && zm[j]) hits++;
      m_cnt = (hits > CMAX) ? CMAX : hits;
      m_ovf = (hits > CMAX);
      j = k - CLR - 1;
      shifting = (k >= CLR + 1) && (k < CLR + 1 + neff);
      exp_sig = 1'b0;
      if (shifting) exp_sig = pat[j];
      chk("busy", bus.busy, (k <= kdone));
      chk("done", bus.done, (k == kdone));
      chk("det_ena", bus.det_ena, shifting);
      chk("det_rst", bus.det_rst, (k < CLR + 1) || (k > kdone));
      chk("det_sig", bus.det_sig, exp_sig);
      chk("hit_count", bus.hit_count, m_cnt);
      chk("overflow", bus.overflow, m_ovf);
      if (bus.done) dones++;
      bus.start   = hold;
      bus.pattern = WORD_W'($urandom);
      if (poke && shifting && j == 5) begin
        bus.start   = 1'b1;
        bus.pattern = ~pat;
      end
      bus.det_z = shifting ? zm[j] : 1'($urandom);
`ifdef DETCTRL_ABORT_EN
      bus.abort = (shifting && j == abort_at) || (k >= kdone && 1'($urandom));
`endif
    end
    chk("done_pulses", dones, 1);
  endtask

  task automatic reset_mid_session();
    bus.pattern = WORD_W'($urandom);
    bus.len     = LEN_W'(WORD_W);
    bus.start   = 1'b1;
    bus.det_z   = 1'b1;
`ifdef DETCTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    for (int k = 1; k <= CLR + 1 + 10; k++) begin
      cycle();
      bus.start = 1'b0;
    end
    chk("pre_rst.hit_count", bus.hit_count, 10);
    chk("pre_rst.det_ena", bus.det_ena, 1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    m_cnt = 0;
    m_ovf = 1'b0;
    chk_idle("mid_rst");
    idle_cycles(4);
  endtask

  initial begin
    logic [31:0] zm;
    int ln, ab;
    bit hold;
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;
    bus.det_z   = 1'b0;
`ifdef DETCTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    rst = 1'b0;
    repeat (3) cycle();
    chk_idle("reset");
    rst = 1'b1;
    idle_cycles(2);

    // Basic pattern with hits on shift cycles 3 and 7.
    run_session(24'hC8E2B4, 24, 32'h0000_0088, 1'b0, 1'b0, -1);
    idle_cycles(2);
    // Zero length and over-length requests.
    run_session(WORD_W'($urandom), 0, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
    run_session(WORD_W'($urandom), 30, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
    // Saturation, persistence in IDLE, then cleared by next start.
    run_session(WORD_W'($urandom), 20, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
    idle_cycles(3);
    run_session(WORD_W'($urandom), 6, 32'h0000_0005, 1'b0, 1'b0, -1);
    // Start pulsed while busy, then start held across back-to-back sessions.
    run_session(WORD_W'($urandom), 16, 32'($urandom), 1'b1, 1'b0, -1);
    run_session(WORD_W'($urandom), 9, 32'($urandom), 1'b0, 1'b1, -1);
    run_session(WORD_W'($urandom), 12, 32'($urandom), 1'b0, 1'b0, -1);
    idle_cycles(1);
    reset_mid_session();
`ifdef DETCTRL_ABORT_EN
    run_session(WORD_W'($urandom), 24, 32'h0000_0014, 1'b0, 1'b0, 4);
    idle_cycles(1);
`endif

    for (int s = 0; s < 40; s++) begin
      ln   = ($urandom_range(0, 7) == 0) ? $urandom_range(25, 31) : $urandom_range(0, 24);
      zm   = 32'($urandom);
      hold = ($urandom_range(0, 3) == 0);
      ab   = -1;
`ifdef DETCTRL_ABORT_EN
      if ($urandom_range(0, 2) == 0) ab = $urandom_range(0, 26);
`endif
      run_session(WORD_W'($urandom), ln, zm, ($urandom_range(0, 2) == 0), hold, ab);
      if (!hold) idle_cycles($urandom_range(0, 3));
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/detector_session_ctrl.md
Name: detector_session_ctrl

Overview:
- Sequences one sequence_detector instance through complete test sessions.
- On a start request it:
  - latches a pattern word and a bit count;
  - clears the detector;
  - shifts the pattern serially into the detector's signal input, one bit per clock;
  - counts the detection flags returned by the detector;
  - reports completion with a one-cycle done pulse.
- Sits between the system/bench control logic and the detector. It owns the detector's rst, ena and sig_to_test inputs.

Parameters:
- WORD_W, 24, maximum pattern length in bits.
- LEN_W, $clog2(WORD_W+1), width of the length field.
- CNT_W, 8, width of the detection counter.
- CLR_CYCLES, 2, number of cycles det_rst is held high at session start (must be at least 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  session request; sampled only in IDLE.
- pattern  in  WORD_W  bits to send, pattern[0] first; latched on accepted start.
- len  in  LEN_W  number of bits to send; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until DONE is exited.
- done  out  1  one-cycle pulse at session end.
- det_rst  out  1  active-high reset to the detector.
- det_ena  out  1  enable to the detector.
- det_sig  out  1  serial bit to the detector's sig_to_test.
- det_z  in  1  detector's Mealy detection flag.
- hit_count  out  CNT_W  detections in the current/last session.
- overflow  out  1  sticky; set when hit_count saturates.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE; busy=0, done=0, det_rst=1, det_ena=0, det_sig=0, hit_count=0, overflow=0.
  - Reset mid-session abandons the session immediately, with no done pulse.
- States and transitions:
  - IDLE: det_rst=1, det_ena=0. On start=1:
    - latch pattern;
    - latch len clamped to WORD_W;
    - clear hit_count and overflow;
    - go to CLEAR.
  - CLEAR: det_rst=1, det_ena=0. Stays CLR_CYCLES cycles, then goes to SHIFT with bit index=0. If the latched len=0, goes to DONE instead.
  - SHIFT: det_rst=0, det_ena=1, det_sig=pattern_q[index].
    - Each cycle, det_z is sampled at the rising edge; if det_z=1, hit_count increments.
    - index increments each cycle.
    - After the cycle where index = len-1, go to DONE.
    - Exactly len SHIFT cycles occur.
  - DONE: done=1 for exactly one cycle; det_ena=0, det_rst=0 (detector state is held for inspection); busy still 1. Then go to IDLE.
- Latency: the first bit is presented CLR_CYCLES+1 cycles after start is sampled. done asserts CLR_CYCLES+len+1 cycles after start is sampled.
- busy and handshake:
  - busy=1 in CLEAR, SHIFT and DONE.
  - start while busy is ignored, not queued.
  - start held high continuously begins a new session on the cycle after DONE.
- Counting: det_z is sampled only in SHIFT; det_z outside SHIFT is ignored.
- Saturation: at hit_count = 2^CNT_W-1, a further hit holds the count and sets overflow.
- Persistence: hit_count and overflow hold their values in IDLE until the next accepted start.
- All outputs are registered except det_sig, which is a mux of pattern_q by index.

Optional Feature:
- Macro: DETCTRL_ABORT_EN.
- When defined:
  - adds input port abort (1 bit);
  - abort=1 in CLEAR or SHIFT forces DONE on the next cycle;
  - done pulses, and hit_count keeps the hits counted so far (including a hit sampled in the abort cycle);
  - abort in IDLE or DONE is ignored.
- When undefined: no abort port; sessions always run to completion.

Decomposition:
- Shared package detector_pkg holds:
  - enum ctrl_state_t {IDLE, CLEAR, SHIFT, DONE};
  - default localparams for WORD_W and CNT_W, shared with the detector bench.
- Sub-module sat_counter (parameter CNT_W; ports clr, inc, count, ovf) implements the saturating hit counter and sticky overflow.
- The FSM, pattern register and index counter stay in the top module.

Test Plan:
- Basic session: pattern=24'hC8E2B4 (bit0 first), len=24, det_z forced high in SHIFT cycles 3 and 7 → det_sig reproduces pattern bits 0..23 in order; hit_count=2; done pulses exactly once, 27 cycles after start.
- Zero and overlength:
  - len=0 → CLEAR then DONE, no SHIFT cycles, hit_count=0, det_ena never high.
  - len=30 → exactly 24 SHIFT cycles.
- Saturation: CNT_W=4, len=20, det_z=1 throughout SHIFT → hit_count=15, overflow=1. The next start clears both.
- Start while busy: pulse start at SHIFT cycle 5 with a different pattern → ignored; original pattern completes; busy falls the cycle after done.
- Reset mid-session: rst=0 at SHIFT cycle 10 → next cycle IDLE, det_rst=1, hit_count=0, no done pulse.
- With DETCTRL_ABORT_EN: abort at SHIFT cycle 4 while det_z=1 on cycles 2 and 4 → done the next cycle, hit_count=2, det_ena=0.
